pe_tile_scheduler: RTL and testbench
====================================

Name: pe_tile_scheduler

Overview:
Sequences one PE datapath controller through a tiled convolution pass. It accepts a tile-loop configuration and drives the PE instruction bits (start/stall/reset). It paces the input and weight streams with rdy/ack handshakes and hands each finished tile's psums downstream before starting the next tile. It sits between the array-level config/feeder logic and the PE's DataPathController.

Parameters:
PCH_DW, 6, width of channel-per-pass loop bound
R_DW, 6, width of filter-row loop bound
PM_DW, 6, width of output-map loop bound
TW_DW, 8, width of output-width loop bound
NTILE_DW, 8, width of tile count

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_cfg_rdy  in  1  config valid
o_cfg_ack  out  1  config accepted (transfer when i_cfg_rdy && o_cfg_ack)
i_cfg_pch  in  PCH_DW  channel loop bound
i_cfg_r  in  R_DW  filter-row loop bound
i_cfg_pm  in  PM_DW  output-map loop bound
i_cfg_tw  in  TW_DW  output-width loop bound
i_cfg_ntile  in  NTILE_DW  number of tiles
i_in_rdy  in  1  input beat available
o_in_ack  out  1  input beat consumed
i_w_rdy  in  1  weight beat available
o_w_ack  out  1  weight beat consumed
o_pe_start  out  1  PE inst.start
o_pe_stall  out  1  PE inst.stall
o_pe_reset  out  1  PE inst.reset (1 = run, 0 = force PE to IDLE)
o_psum_rdy  out  1  tile psums ready to drain
i_psum_ack  in  1  drain accepted
i_abort  in  1  abort current job
o_busy  out  1  state != IDLE
o_tile_idx  out  NTILE_DW  current tile index
o_done  out  1  one-cycle pulse at job completion

Behaviour:
- States: IDLE, START, RUN, DRAIN, ABORT.
- Registered state, counters and o_done; all other outputs are combinational decodes. On i_rst: state=IDLE, counters=0, o_tile_idx=0, and every output is 0.
- IDLE:
  - o_cfg_ack=1.
  - On i_cfg_rdy, latch all cfg fields; a field equal to 0 is stored as 1. Go to START.
- START (1 cycle): o_pe_start=1, o_pe_reset=1, then go to RUN.
- RUN:
  - o_pe_reset=1.
  - A step occurs when i_in_rdy && i_w_rdy. In that cycle o_in_ack = o_w_ack = 1; both acks are always asserted together.
  - o_pe_stall = !(i_in_rdy && i_w_rdy).
  - Nested counters advance on each step: ch (innermost, 0..pch-1), then r, then m, then tw (outermost). Each counter wraps to 0 and carries to the next.
  - Steps per tile = pch*r*pm*tw.
  - On the step where all four counters are at max, clear the counters and go to DRAIN.
- DRAIN:
  - o_pe_reset=1, o_pe_stall=1, o_psum_rdy=1 until i_psum_ack.
  - On ack: if o_tile_idx == ntile-1, assert o_done the next cycle, clear o_tile_idx and go to IDLE. Otherwise increment o_tile_idx and go to START.
- ABORT (1 cycle):
  - i_abort in START/RUN/DRAIN goes to ABORT next cycle and takes priority over every other transition.
  - In the abort-request cycle, o_in_ack, o_w_ack and o_psum_rdy are forced to 0.
  - In ABORT: o_pe_reset=0, counters and tile_idx cleared, then go to IDLE. No o_done is issued.
  - i_abort in IDLE is ignored.
- o_pe_reset=0 in IDLE and ABORT. o_pe_stall=0 outside RUN/DRAIN. o_busy=1 in every state except IDLE.
- Latency from config accept to first possible ack is 2 cycles (accept cycle, START, then RUN).
- Config is not sampled while busy. Latched bounds are constant for the whole job.
- Async i_rst mid-job returns to IDLE immediately with all outputs 0. The PE is brought back by the system reset, not by this block.

Test Plan:
- cfg pch=2,r=3,pm=1,tw=1,ntile=1, in/w rdy always high, cfg accepted cycle 0 -> start pulse cycle 1; acks cycles 2-7 (6 steps); psum_rdy cycle 8; ack at cycle 8 -> o_done cycle 9; busy low cycle 9.
- Same cfg, i_w_rdy low cycles 4-6 -> o_pe_stall high cycles 4-6 with no acks; exactly 6 acked steps in total; psum_rdy cycle 11.
- ntile=3, pch=r=pm=tw=1, psum_ack delayed 2 cycles each tile -> three START pulses; o_tile_idx 0,1,2; one o_done; o_tile_idx returns to 0.
- cfg pch=0,r=2,pm=0,tw=0 -> treated as 1,2,1,1; exactly 2 steps per tile.
- i_abort asserted at the 3rd RUN step of pch=4,r=4 -> no ack that cycle; o_pe_reset=0 for 1 cycle; IDLE after; no o_done; a new cfg is accepted next.
- i_rst pulsed during DRAIN -> all outputs 0 asynchronously; o_cfg_ack=1 after release.

Source files
------------

// File: rtl/pe_tile_scheduler.sv
// ---------------------------------------------------------------------------
// pe_tile_scheduler
//
// Sequences one PE datapath controller through a tiled convolution pass.
// A job is configured with four nested loop bounds (channel, filter row,
// output map, output width) and a tile count. For every tile the block pulses
// the PE start bit, then paces the input and weight streams (one step per
// cycle in which both are available), then holds the PE stalled while the
// tile's psums are drained downstream. After the last tile it pulses o_done.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_cfg_rdy/o_cfg_ack config handshake; i_cfg_* fields latched on transfer
//   i_in_rdy/o_in_ack   input stream beat handshake
//   i_w_rdy/o_w_ack     weight stream beat handshake (acked with input)
//   o_pe_start/stall/reset  PE instruction bits (reset: 1 = run, 0 = idle)
//   o_psum_rdy/i_psum_ack   tile psum drain handshake
//   i_abort             abandon the current job (ignored when idle)
//   o_busy              any state other than IDLE
//   o_tile_idx          index of the tile currently in flight
//   o_done              one-cycle pulse after the last tile drains
// ---------------------------------------------------------------------------
module pe_tile_scheduler #(
  parameter int PCH_DW   = 6,
  parameter int R_DW     = 6,
  parameter int PM_DW    = 6,
  parameter int TW_DW    = 8,
  parameter int NTILE_DW = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_rdy,
  output logic                o_cfg_ack,
  input  logic [PCH_DW-1:0]   i_cfg_pch,
  input  logic [R_DW-1:0]     i_cfg_r,
  input  logic [PM_DW-1:0]    i_cfg_pm,
  input  logic [TW_DW-1:0]    i_cfg_tw,
  input  logic [NTILE_DW-1:0] i_cfg_ntile,
  input  logic                i_in_rdy,
  output logic                o_in_ack,
  input  logic                i_w_rdy,
  output logic                o_w_ack,
  output logic                o_pe_start,
  output logic                o_pe_stall,
  output logic                o_pe_reset,
  output logic                o_psum_rdy,
  input  logic                i_psum_ack,
  input  logic                i_abort,
  output logic                o_busy,
  output logic [NTILE_DW-1:0] o_tile_idx,
  output logic                o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN,
    S_ABORT
  } state_t;

  state_t state_q, state_d;

  // Latched loop bounds (never zero once latched)
  logic [PCH_DW-1:0]   pch_q, pch_d;
  logic [R_DW-1:0]     r_q, r_d;
  logic [PM_DW-1:0]    pm_q, pm_d;
  logic [TW_DW-1:0]    tw_q, tw_d;
  logic [NTILE_DW-1:0] ntile_q, ntile_d;

  // Loop counters
  logic [PCH_DW-1:0]   ch_cnt_q, ch_cnt_d;
  logic [R_DW-1:0]     r_cnt_q, r_cnt_d;
  logic [PM_DW-1:0]    m_cnt_q, m_cnt_d;
  logic [TW_DW-1:0]    tw_cnt_q, tw_cnt_d;
  logic [NTILE_DW-1:0] tile_q, tile_d;
  logic                done_q, done_d;

  // Combinational output decodes before reset gating
  logic cfg_ack_c, in_ack_c, pe_start_c, pe_stall_c, pe_reset_c, psum_rdy_c;
  logic busy_c;

  logic step;
  logic ch_last, r_last, m_last, tw_last, tile_last;

  assign step      = i_in_rdy && i_w_rdy;
  assign ch_last   = (ch_cnt_q == pch_q - 1'b1);
  assign r_last    = (r_cnt_q == r_q - 1'b1);
  assign m_last    = (m_cnt_q == pm_q - 1'b1);
  assign tw_last   = (tw_cnt_q == tw_q - 1'b1);
  assign tile_last = (tile_q == ntile_q - 1'b1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      pch_q    <= '0;
      r_q      <= '0;
      pm_q     <= '0;
      tw_q     <= '0;
      ntile_q  <= '0;
      ch_cnt_q <= '0;
      r_cnt_q  <= '0;
      m_cnt_q  <= '0;
      tw_cnt_q <= '0;
      tile_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pch_q    <= pch_d;
      r_q      <= r_d;
      pm_q     <= pm_d;
      tw_q     <= tw_d;
      ntile_q  <= ntile_d;
      ch_cnt_q <= ch_cnt_d;
      r_cnt_q  <= r_cnt_d;
      m_cnt_q  <= m_cnt_d;
      tw_cnt_q <= tw_cnt_d;
      tile_q   <= tile_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pch_d      = pch_q;
    r_d        = r_q;
    pm_d       = pm_q;
    tw_d       = tw_q;
    ntile_d    = ntile_q;
    ch_cnt_d   = ch_cnt_q;
    r_cnt_d    = r_cnt_q;
    m_cnt_d    = m_cnt_q;
    tw_cnt_d   = tw_cnt_q;
    tile_d     = tile_q;
    done_d     = 1'b0;
    cfg_ack_c  = 1'b0;
    in_ack_c   = 1'b0;
    pe_start_c = 1'b0;
    pe_stall_c = 1'b0;
    pe_reset_c = 1'b0;
    psum_rdy_c = 1'b0;
    busy_c     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        cfg_ack_c = 1'b1;
        if (i_cfg_rdy) begin
          // A zero bound would make the loop degenerate; run it once instead
          pch_d   = (i_cfg_pch   == '0) ? PCH_DW'(1)   : i_cfg_pch;
          r_d     = (i_cfg_r     == '0) ? R_DW'(1)     : i_cfg_r;
          pm_d    = (i_cfg_pm    == '0) ? PM_DW'(1)    : i_cfg_pm;
          tw_d    = (i_cfg_tw    == '0) ? TW_DW'(1)    : i_cfg_tw;
          ntile_d = (i_cfg_ntile == '0) ? NTILE_DW'(1) : i_cfg_ntile;
          state_d = S_START;
        end
      end

      S_START: begin
        pe_start_c = 1'b1;
        pe_reset_c = 1'b1;
        state_d    = i_abort ? S_ABORT : S_RUN;
      end

      S_RUN: begin
        pe_reset_c = 1'b1;
        pe_stall_c = !step;
        if (i_abort) begin
          state_d = S_ABORT;
        end else if (step) begin
          in_ack_c = 1'b1;
          // Ripple-carry through ch -> r -> m -> tw
          if (ch_last) begin
            ch_cnt_d = '0;
            if (r_last) begin
              r_cnt_d = '0;
              if (m_last) begin
                m_cnt_d = '0;
                if (tw_last) begin
                  tw_cnt_d = '0;
                  state_d  = S_DRAIN;
                end else begin
                  tw_cnt_d = tw_cnt_q + 1'b1;
                end
              end else begin
                m_cnt_d = m_cnt_q + 1'b1;
              end
            end else begin
              r_cnt_d = r_cnt_q + 1'b1;
            end
          end else begin
            ch_cnt_d = ch_cnt_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        pe_reset_c = 1'b1;
        pe_stall_c = 1'b1;
        if (i_abort) begin
          state_d = S_ABORT;
        end else begin
          psum_rdy_c = 1'b1;
          if (i_psum_ack) begin
            if (tile_last) begin
              done_d  = 1'b1;
              tile_d  = '0;
              state_d = S_IDLE;
            end else begin
              tile_d  = tile_q + 1'b1;
              state_d = S_START;
            end
          end
        end
      end

      S_ABORT: begin
        ch_cnt_d = '0;
        r_cnt_d  = '0;
        m_cnt_d  = '0;
        tw_cnt_d = '0;
        tile_d   = '0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decoded outputs are masked by reset so they drop the instant it asserts,
  // not only once the state register has been cleared.
  assign o_cfg_ack  = cfg_ack_c  && !i_rst;
  assign o_in_ack   = in_ack_c   && !i_rst;
  assign o_w_ack    = in_ack_c   && !i_rst;
  assign o_pe_start = pe_start_c && !i_rst;
  assign o_pe_stall = pe_stall_c && !i_rst;
  assign o_pe_reset = pe_reset_c && !i_rst;
  assign o_psum_rdy = psum_rdy_c && !i_rst;
  assign o_busy     = busy_c     && !i_rst;
  assign o_tile_idx = tile_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_pe_tile_scheduler.sv
module tb_pe_tile_scheduler;

  logic       i_clk, i_rst;
  logic       i_cfg_rdy, o_cfg_ack;
  logic [5:0] i_cfg_pch, i_cfg_r, i_cfg_pm;
  logic [7:0] i_cfg_tw, i_cfg_ntile;
  logic       i_in_rdy, o_in_ack, i_w_rdy, o_w_ack;
  logic       o_pe_start, o_pe_stall, o_pe_reset;
  logic       o_psum_rdy, i_psum_ack, i_abort, o_busy, o_done;
  logic [7:0] o_tile_idx;

  pe_tile_scheduler dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cfg_rdy(i_cfg_rdy), .o_cfg_ack(o_cfg_ack),
    .i_cfg_pch(i_cfg_pch), .i_cfg_r(i_cfg_r), .i_cfg_pm(i_cfg_pm),
    .i_cfg_tw(i_cfg_tw), .i_cfg_ntile(i_cfg_ntile),
    .i_in_rdy(i_in_rdy), .o_in_ack(o_in_ack),
    .i_w_rdy(i_w_rdy), .o_w_ack(o_w_ack),
    .o_pe_start(o_pe_start), .o_pe_stall(o_pe_stall), .o_pe_reset(o_pe_reset),
    .o_psum_rdy(o_psum_rdy), .i_psum_ack(i_psum_ack), .i_abort(i_abort),
    .o_busy(o_busy), .o_tile_idx(o_tile_idx), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int tile;
    int steps;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   step_cnt = 0;
  int   start_cnt = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Sample just after the negative edge, once inputs for this cycle are set.
  // Tracks handshakes and scores each tile drain against the expected queue.
  task automatic sample();
    exp_t e;
    #1;
    if (o_in_ack || o_w_ack) check("ack_pair", 32'({o_in_ack, o_w_ack}), 32'b11);
    if (o_pe_start) begin
      start_cnt++;
      step_cnt = 0;
    end
    if (o_in_ack) step_cnt++;
    if (o_psum_rdy && i_psum_ack) begin
      check("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("drain_tile_idx", 32'(o_tile_idx), 32'(e.tile));
        check("drain_steps", 32'(step_cnt), 32'(e.steps));
      end
    end
    if (o_done) done_cnt++;
  endtask

  task automatic adv();
    @(negedge i_clk);
  endtask

  task automatic set_cfg(input int pch, input int r, input int pm, input int tw, input int nt);
    i_cfg_pch   = 6'(pch);
    i_cfg_r     = 6'(r);
    i_cfg_pm    = 6'(pm);
    i_cfg_tw    = 8'(tw);
    i_cfg_ntile = 8'(nt);
  endtask

  task automatic push_job(input int pch, input int r, input int pm, input int tw, input int nt);
    int steps;
    steps = (pch == 0 ? 1 : pch) * (r == 0 ? 1 : r) * (pm == 0 ? 1 : pm) * (tw == 0 ? 1 : tw);
    for (int t = 0; t < (nt == 0 ? 1 : nt); t++) sb.push_back('{t, steps});
  endtask

  task automatic run_job(input int pch, input int r, input int pm, input int tw, input int nt,
                         input int dly, input bit rnd);
    int  wcnt;
    int  ncyc;
    bit  fin;
    push_job(pch, r, pm, tw, nt);
    set_cfg(pch, r, pm, tw, nt);
    i_cfg_rdy = 1'b1;
    i_in_rdy  = 1'b1;
    i_w_rdy   = 1'b1;
    sample();
    check("job_cfg_ack", 32'(o_cfg_ack), 32'd1);
    adv();
    i_cfg_rdy = 1'b0;
    fin  = 1'b0;
    wcnt = 0;
    ncyc = 0;
    while (!fin && ncyc < 3000) begin
      if (rnd) begin
        i_in_rdy = 1'($urandom_range(0, 1));
        i_w_rdy  = 1'($urandom_range(0, 1));
      end
      i_psum_ack = 1'b0;
      if (o_psum_rdy) begin
        if (wcnt >= dly) i_psum_ack = 1'b1;
        wcnt++;
      end else begin
        wcnt = 0;
      end
      sample();
      if (o_done) fin = 1'b1;
      adv();
      ncyc++;
    end
    i_psum_ack = 1'b0;
    i_in_rdy   = 1'b1;
    i_w_rdy    = 1'b1;
    check("job_finished_in_budget", 32'(fin), 32'd1);
  endtask

  int s0, d0;

  initial begin
    i_rst = 1'b1;
    i_cfg_rdy = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    i_in_rdy = 1'b0;
    i_w_rdy = 1'b0;
    i_psum_ack = 1'b0;
    i_abort = 1'b0;

    // Reset state
    repeat (2) @(negedge i_clk);
    #1;
    check("reset_outputs", 32'({o_cfg_ack, o_in_ack, o_w_ack, o_pe_start, o_pe_stall,
                               o_pe_reset, o_psum_rdy, o_busy, o_done, o_tile_idx}), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("post_reset_cfg_ack", 32'(o_cfg_ack), 32'd1);
    check("post_reset_busy", 32'(o_busy), 32'd0);
    adv();

    // T1: pch=2 r=3, streams always ready
    push_job(2, 3, 1, 1, 1);
    set_cfg(2, 3, 1, 1, 1);
    i_in_rdy = 1'b1;
    i_w_rdy = 1'b1;
    i_cfg_rdy = 1'b1;
    sample();
    check("t1_cfg_ack_c0", 32'(o_cfg_ack), 32'd1);
    adv();
    i_cfg_rdy = 1'b0;
    sample();
    check("t1_start_c1", 32'({o_pe_start, o_pe_reset, o_busy, o_in_ack}), 32'b1110);
    adv();
    for (int c = 2; c <= 7; c++) begin
      sample();
      check("t1_ack", 32'({o_in_ack, o_pe_stall}), 32'b10);
      adv();
    end
    i_psum_ack = 1'b1;
    sample();
    check("t1_psum_rdy_c8", 32'({o_psum_rdy, o_pe_stall, o_in_ack}), 32'b110);
    adv();
    i_psum_ack = 1'b0;
    sample();
    check("t1_done_c9", 32'({o_done, o_busy}), 32'b10);
    adv();
    sample();
    check("t1_done_pulse_c10", 32'(o_done), 32'd0);
    adv();

    // T2: weight stream gaps in cycles 4..6
    push_job(2, 3, 1, 1, 1);
    for (int c = 0; c <= 12; c++) begin
      i_cfg_rdy  = (c == 0);
      i_w_rdy    = !(c >= 4 && c <= 6);
      i_psum_ack = (c == 11);
      sample();
      if (c >= 2 && c <= 10) begin
        check("t2_ack", 32'(o_in_ack), 32'(!(c >= 4 && c <= 6)));
        check("t2_stall", 32'(o_pe_stall), 32'(c >= 4 && c <= 6));
      end
      if (c == 10) check("t2_no_psum_c10", 32'(o_psum_rdy), 32'd0);
      if (c == 11) check("t2_psum_rdy_c11", 32'(o_psum_rdy), 32'd1);
      if (c == 12) check("t2_done_c12", 32'(o_done), 32'd1);
      adv();
    end
    i_cfg_rdy = 1'b0;
    i_w_rdy = 1'b1;
    i_psum_ack = 1'b0;

    // T3: three unit tiles, drain acknowledged after a 2-cycle delay
    s0 = start_cnt;
    d0 = done_cnt;
    run_job(1, 1, 1, 1, 3, 2, 1'b0);
    check("t3_start_pulses", 32'(start_cnt - s0), 32'd3);
    check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t3_tile_idx_back_to_0", 32'(o_tile_idx), 32'd0);

    // T4: zero bounds treated as one, random stream readiness
    run_job(0, 2, 0, 0, 2, 0, 1'b1);

    // T5: abort on the 3rd RUN step
    d0 = done_cnt;
    set_cfg(4, 4, 1, 1, 1);
    i_cfg_rdy = 1'b1;
    sample();
    adv();
    i_cfg_rdy = 1'b0;
    sample();
    check("t5_start", 32'(o_pe_start), 32'd1);
    adv();
    for (int c = 2; c <= 3; c++) begin
      sample();
      check("t5_pre_abort_ack", 32'(o_in_ack), 32'd1);
      adv();
    end
    i_abort = 1'b1;
    sample();
    check("t5_abort_no_ack", 32'({o_in_ack, o_w_ack, o_psum_rdy}), 32'd0);
    adv();
    i_abort = 1'b0;
    sample();
    check("t5_abort_state", 32'({o_pe_reset, o_busy, o_in_ack}), 32'b010);
    adv();
    sample();
    check("t5_idle_after", 32'({o_busy, o_cfg_ack, o_done, o_tile_idx}), 32'({1'b0, 1'b1, 1'b0, 8'd0}));
    adv();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    run_job(3, 1, 2, 1, 1, 1, 1'b1);

    // T6: async reset while draining
    set_cfg(1, 1, 1, 1, 1);
    i_cfg_rdy = 1'b1;
    sample();
    adv();
    i_cfg_rdy = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      sample();
      adv();
    end
    sample();
    check("t6_in_drain", 32'(o_psum_rdy), 32'd1);
    i_rst = 1'b1;
    #1;
    check("t6_reset_outputs", 32'({o_cfg_ack, o_in_ack, o_w_ack, o_pe_start, o_pe_stall,
                                  o_pe_reset, o_psum_rdy, o_busy, o_done, o_tile_idx}), 32'd0);
    adv();
    i_rst = 1'b0;
    #1;
    check("t6_cfg_ack_after_release", 32'({o_cfg_ack, o_busy}), 32'b10);
    adv();

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("total_done_pulses", 32'(done_cnt), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
